// File: rtl/cpu_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cpu_seq_ctrl
//  Description : Multi-cycle instruction sequencer for the 19-bit CPU.
//                Fetches over a req/ack handshake, then steps the datapath
//                through DECODE, EXEC, MEM and WB. It is the only block
//                that advances the PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_seq_ctrl #(
    parameter int ADDR_W = 14          // must be greater than 8 (branch offset width)
) (
    input  logic              clk,
    input  logic              rst,
    // instruction memory
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [18:0]       imem_rdata,
    // data memory
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ack,
    // datapath
    input  logic              alu_zero,
    output logic [4:0]        alu_opcode,
    output logic [4:0]        alu_funct,
    output logic              alu_src_imm,
    output logic              rf_we,
    output logic              wb_sel,
    // status
    output logic [18:0]       ir,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal,
    output logic [15:0]       retired
);

    // ------------------------------------------------------------------
    // Opcode map
    // ------------------------------------------------------------------
    localparam logic [4:0] c_OP_ART = 5'h00;
    localparam logic [4:0] c_OP_LOG = 5'h01;
    localparam logic [4:0] c_OP_CRY = 5'h02;
    localparam logic [4:0] c_OP_IMM = 5'h03;
    localparam logic [4:0] c_OP_LD  = 5'h04;
    localparam logic [4:0] c_OP_ST  = 5'h05;
    localparam logic [4:0] c_OP_BEQ = 5'h06;
    localparam logic [4:0] c_OP_JMP = 5'h07;
    localparam logic [4:0] c_OP_HLT = 5'h1F;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [18:0]         ir_q;
    logic [15:0]         retired_q;
    logic                illegal_q;
    logic                halted_q;
    logic                imem_req_q;
    logic                dmem_req_q;
    logic                dmem_we_q;
    logic                rf_we_q;
    logic                wb_sel_q;

    // ------------------------------------------------------------------
    // Decode of the latched instruction
    // ------------------------------------------------------------------
    logic [4:0]          op;
    logic                is_alu;
    logic                is_ld;
    logic                is_st;
    logic                is_beq;
    logic                is_jmp;
    logic                is_hlt;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   br_target;
    logic [ADDR_W-1:0]   jmp_target;

    assign op     = ir_q[18:14];
    assign is_alu = (op == c_OP_ART) || (op == c_OP_LOG) ||
                    (op == c_OP_CRY) || (op == c_OP_IMM);
    assign is_ld  = (op == c_OP_LD);
    assign is_st  = (op == c_OP_ST);
    assign is_beq = (op == c_OP_BEQ);
    assign is_jmp = (op == c_OP_JMP);
    assign is_hlt = (op == c_OP_HLT);

    assign pc_inc = pc_q + ADDR_W'(1);

    // pc already points past the branch, so the offset is applied to it
    // directly; the sum wraps naturally at the PC width.
    assign br_target = pc_q + {{(ADDR_W-8){ir_q[7]}}, ir_q[7:0]};

    // The jump target field is 14 bits; narrower PCs take the low bits,
    // wider PCs zero-extend it.
    generate
        if (ADDR_W <= 14) begin : g_tgt_slice
            assign jmp_target = ir_q[ADDR_W-1:0];
        end else begin : g_tgt_zext
            assign jmp_target = {{(ADDR_W-14){1'b0}}, ir_q[13:0]};
        end
    endgenerate

    // Sequencer FSM: state, PC, IR, counters and all strobes are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            retired_q  <= '0;
            illegal_q  <= 1'b0;
            halted_q   <= 1'b0;
            // FETCH is the reset state, so the fetch request is already
            // primed; it is masked at the port while rst is high.
            imem_req_q <= 1'b1;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            wb_sel_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_q       <= imem_rdata;
                        pc_q       <= pc_inc;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    state_q <= S_EXEC;
                end

                S_EXEC: begin
                    if (is_alu) begin
                        rf_we_q  <= 1'b1;
                        wb_sel_q <= 1'b0;
                        state_q  <= S_WB;
                    end else if (is_ld || is_st) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= is_st;
                        state_q    <= S_MEM;
                    end else if (is_beq) begin
                        if (alu_zero) begin
                            pc_q <= br_target;
                        end
                        retired_q  <= retired_q + 16'd1;
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end else if (is_jmp) begin
                        pc_q       <= jmp_target;
                        retired_q  <= retired_q + 16'd1;
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end else if (is_hlt) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        illegal_q <= 1'b1;
                        halted_q  <= 1'b1;
                        state_q   <= S_HALT;
                    end
                end

                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (is_st) begin
                            retired_q  <= retired_q + 16'd1;
                            imem_req_q <= 1'b1;
                            state_q    <= S_FETCH;
                        end else begin
                            rf_we_q  <= 1'b1;
                            wb_sel_q <= 1'b1;
                            state_q  <= S_WB;
                        end
                    end
                end

                S_WB: begin
                    rf_we_q    <= 1'b0;
                    retired_q  <= retired_q + 16'd1;
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end

                S_HALT: begin
                    state_q <= S_HALT;
                end

                default: begin
                    state_q    <= S_FETCH;
                    imem_req_q <= 1'b1;
                    dmem_req_q <= 1'b0;
                    dmem_we_q  <= 1'b0;
                    rf_we_q    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes are masked by rst so an in-flight request drops the
    // moment reset is asserted, independent of the clock.
    // ------------------------------------------------------------------
    assign imem_req    = imem_req_q & ~rst;
    assign dmem_req    = dmem_req_q & ~rst;
    assign dmem_we     = dmem_we_q  & ~rst;
    assign rf_we       = rf_we_q    & ~rst;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign ir          = ir_q;
    assign alu_opcode  = ir_q[18:14];
    assign alu_funct   = ir_q[4:0];
    assign alu_src_imm = (op == c_OP_IMM) || is_ld || is_st;
    assign wb_sel      = wb_sel_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign retired     = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_seq_ctrl
//  Description : Self-checking bench for cpu_seq_ctrl. An instruction-level
//                reference model predicts PC, retire count, latency and
//                strobe counts for each instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_seq_ctrl;

    localparam int ADDR_W = 14;

    localparam logic [4:0] OP_ART = 5'h00;
    localparam logic [4:0] OP_LOG = 5'h01;
    localparam logic [4:0] OP_CRY = 5'h02;
    localparam logic [4:0] OP_IMM = 5'h03;
    localparam logic [4:0] OP_LD  = 5'h04;
    localparam logic [4:0] OP_ST  = 5'h05;
    localparam logic [4:0] OP_BEQ = 5'h06;
    localparam logic [4:0] OP_JMP = 5'h07;
    localparam logic [4:0] OP_HLT = 5'h1F;
    localparam logic [4:0] OP_BAD = 5'h10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack = 1'b0;
    logic [18:0]       imem_rdata = '0;
    logic              dmem_req;
    logic              dmem_we;
    logic              dmem_ack = 1'b0;
    logic              alu_zero = 1'b0;
    logic [4:0]        alu_opcode;
    logic [4:0]        alu_funct;
    logic              alu_src_imm;
    logic              rf_we;
    logic              wb_sel;
    logic [18:0]       ir;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              illegal;
    logic [15:0]       retired;

    cpu_seq_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .alu_zero   (alu_zero),
        .alu_opcode (alu_opcode),
        .alu_funct  (alu_funct),
        .alu_src_imm(alu_src_imm),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .ir         (ir),
        .pc         (pc),
        .halted     (halted),
        .illegal    (illegal),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // architectural model state
    logic [ADDR_W-1:0] m_pc;
    logic [15:0]       m_ret;

    typedef struct {
        int lat; int n_ireq; int n_dreq; int n_dwe; int n_rfwe; int rfwe_cyc;
        bit wbsel; bit addr_bad; bit timeout;
    } obs_t;

    typedef struct {
        int lat; int n_ireq; int n_dreq; int n_dwe; int n_rfwe;
        bit wbsel; bit halts; bit ill;
    } exp_t;

    // Instruction-level model: latency from the per-class cycle counts plus
    // wait states, and the architectural effect on pc / retired.
    task automatic model_step(input logic [18:0] instr, input bit zero,
                              input int iwait, input int dwait, output exp_t e);
        logic [4:0] op;
        int t;
        op = instr[18:14];
        e = '{default: 0};
        e.n_ireq = iwait + 1;
        if (op == OP_ART || op == OP_LOG || op == OP_CRY || op == OP_IMM) begin
            e.lat = 4 + iwait; e.n_rfwe = 1; e.wbsel = 0;
            m_pc = m_pc + 1'b1; m_ret = m_ret + 16'd1;
        end else if (op == OP_LD) begin
            e.lat = 5 + iwait + dwait; e.n_dreq = dwait + 1; e.n_rfwe = 1; e.wbsel = 1;
            m_pc = m_pc + 1'b1; m_ret = m_ret + 16'd1;
        end else if (op == OP_ST) begin
            e.lat = 4 + iwait + dwait; e.n_dreq = dwait + 1; e.n_dwe = dwait + 1;
            m_pc = m_pc + 1'b1; m_ret = m_ret + 16'd1;
        end else if (op == OP_BEQ) begin
            e.lat = 3 + iwait;
            t = int'(m_pc) + 1 + (zero ? int'($signed(instr[7:0])) : 0);
            m_pc = ADDR_W'(t); m_ret = m_ret + 16'd1;
        end else if (op == OP_JMP) begin
            e.lat = 3 + iwait;
            m_pc = instr[13:0]; m_ret = m_ret + 16'd1;
        end else begin
            e.lat = 3 + iwait; e.halts = 1; e.ill = (op != OP_HLT);
            m_pc = m_pc + 1'b1;
        end
    endtask

    // Drives one instruction through the handshakes from the current sample
    // point (DUT in FETCH) until the next fetch request or halt; stray acks
    // are thrown in whenever the matching request is low.
    task automatic run_instr(input logic [18:0] instr, input bit zero,
                             input int iwait, input int dwait,
                             input logic [ADDR_W-1:0] addr, output obs_t o);
        int ii;
        int di;
        bit seen_low;
        ii = 0; di = 0; seen_low = 0;
        o = '{default: 0};
        for (int cyc = 0; cyc <= 100; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 100) begin o.timeout = 1; break; end
            if (cyc > 0 && ((imem_req && seen_low) || halted)) begin o.lat = cyc; break; end
            if (!imem_req) seen_low = 1;
            if (imem_req) begin
                o.n_ireq++;
                if (imem_addr !== addr) o.addr_bad = 1;
                imem_ack   = (ii == iwait);
                imem_rdata = (ii == iwait) ? instr : 19'($urandom);
                ii++;
            end else begin
                imem_ack   = 1'($urandom_range(0, 1));
                imem_rdata = 19'($urandom);
            end
            if (dmem_req) begin
                o.n_dreq++;
                if (dmem_we) o.n_dwe++;
                dmem_ack = (di == dwait);
                di++;
            end else begin
                dmem_ack = 1'($urandom_range(0, 1));
            end
            if (rf_we) begin o.n_rfwe++; o.rfwe_cyc = cyc; o.wbsel = wb_sel; end
            alu_zero = zero;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_ack = 0; dmem_ack = 0; alu_zero = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0; m_pc = '0; m_ret = '0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 0; dmem_ack = 0;
        repeat (2) @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_imem_req got=%0b want=0", imem_req); end
        total++; if ({pc, ir, retired, illegal, halted} !== '0) begin
            bad++; $display("FAIL rst_values pc=%0h ir=%0h retired=%0h illegal=%0b halted=%0b want=all 0", pc, ir, retired, illegal, halted);
        end
        rst = 1'b0; m_pc = '0; m_ret = '0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== '0) begin
            bad++; $display("FAIL rst_release_fetch req=%0b addr=%0h want req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_alu_basic();
        obs_t o; exp_t e;
        logic [18:0] instr;
        instr = {OP_ART, 3'd1, 3'd2, 3'd3, 5'd1};
        run_instr(instr, 1'b0, 0, 0, m_pc, o);
        model_step(instr, 1'b0, 0, 0, e);
        total++; if (o.lat !== 4 || o.timeout) begin bad++; $display("FAIL alu_latency got=%0d want=4", o.lat); end
        total++; if (o.n_rfwe !== 1 || o.rfwe_cyc !== 3) begin
            bad++; $display("FAIL alu_rf_we count=%0d cycle=%0d want count=1 cycle=3", o.n_rfwe, o.rfwe_cyc);
        end
        total++; if (alu_opcode !== OP_ART || alu_funct !== 5'd1) begin
            bad++; $display("FAIL alu_fields op=%0h funct=%0h want op=%0h funct=1", alu_opcode, alu_funct, OP_ART);
        end
        total++; if (pc !== 14'd1 || retired !== 16'd1) begin
            bad++; $display("FAIL alu_pc_retired pc=%0h retired=%0d want pc=1 retired=1", pc, retired);
        end
    endtask

    task automatic test_load_store();
        obs_t o; exp_t e;
        logic [18:0] instr;
        instr = {OP_LD, 3'd4, 3'd5, 8'h12};
        run_instr(instr, 1'b0, 0, 3, m_pc, o);
        model_step(instr, 1'b0, 0, 3, e);
        total++; if (o.n_dreq !== 4 || o.n_dwe !== 0) begin
            bad++; $display("FAIL ld_dmem req_cycles=%0d we_cycles=%0d want 4 and 0", o.n_dreq, o.n_dwe);
        end
        total++; if (o.n_rfwe !== 1 || o.wbsel !== 1'b1 || o.lat !== 8) begin
            bad++; $display("FAIL ld_wb rf_we=%0d wb_sel=%0b lat=%0d want 1 1 8", o.n_rfwe, o.wbsel, o.lat);
        end
        total++; if (alu_src_imm !== 1'b1) begin bad++; $display("FAIL ld_src_imm got=%0b want=1", alu_src_imm); end
        instr = {OP_ST, 3'd6, 3'd7, 8'h34};
        run_instr(instr, 1'b0, 0, 3, m_pc, o);
        model_step(instr, 1'b0, 0, 3, e);
        total++; if (o.n_dreq !== 4 || o.n_dwe !== 4 || o.n_rfwe !== 0 || o.lat !== 7) begin
            bad++; $display("FAIL st_strobes req=%0d we=%0d rf_we=%0d lat=%0d want 4 4 0 7", o.n_dreq, o.n_dwe, o.n_rfwe, o.lat);
        end
        total++; if (pc !== 14'd3 || retired !== 16'd3) begin
            bad++; $display("FAIL ldst_pc_retired pc=%0h retired=%0d want pc=3 retired=3", pc, retired);
        end
    endtask

    task automatic test_branch();
        obs_t o; exp_t e;
        logic [18:0] jmp5;
        logic [18:0] beq;
        jmp5 = {OP_JMP, 14'd5};
        beq  = {OP_BEQ, 3'd1, 3'd2, 8'hFC};
        run_instr(jmp5, 1'b0, 1, 0, m_pc, o);
        model_step(jmp5, 1'b0, 1, 0, e);
        total++; if (imem_addr !== 14'd5 || o.lat !== 4) begin
            bad++; $display("FAIL jmp5 addr=%0h lat=%0d want addr=5 lat=4", imem_addr, o.lat);
        end
        run_instr(beq, 1'b1, 0, 0, m_pc, o);
        model_step(beq, 1'b1, 0, 0, e);
        total++; if (imem_addr !== 14'd2 || o.lat !== 3) begin
            bad++; $display("FAIL beq_taken addr=%0h lat=%0d want addr=2 lat=3", imem_addr, o.lat);
        end
        run_instr(jmp5, 1'b0, 0, 0, m_pc, o);
        model_step(jmp5, 1'b0, 0, 0, e);
        run_instr(beq, 1'b0, 2, 0, m_pc, o);
        model_step(beq, 1'b0, 2, 0, e);
        total++; if (imem_addr !== 14'd6 || o.lat !== 5) begin
            bad++; $display("FAIL beq_not_taken addr=%0h lat=%0d want addr=6 lat=5", imem_addr, o.lat);
        end
    endtask

    task automatic test_jmp_wrap();
        obs_t o; exp_t e;
        logic [18:0] instr;
        instr = {OP_JMP, 14'h3FFF};
        run_instr(instr, 1'b0, 0, 0, m_pc, o);
        model_step(instr, 1'b0, 0, 0, e);
        total++; if (pc !== 14'h3FFF) begin bad++; $display("FAIL jmp_target pc=%0h want=3fff", pc); end
        instr = {OP_LOG, 3'd2, 3'd3, 3'd4, 5'd7};
        run_instr(instr, 1'b0, 0, 0, m_pc, o);
        model_step(instr, 1'b0, 0, 0, e);
        total++; if (pc !== 14'h0000 || o.addr_bad) begin
            bad++; $display("FAIL pc_wrap pc=%0h addr_bad=%0b want pc=0 addr_bad=0", pc, o.addr_bad);
        end
    endtask

    task automatic test_random();
        obs_t o; exp_t e;
        logic [4:0] ops [8];
        logic [18:0] instr;
        logic [ADDR_W-1:0] a;
        int iw; int dw; bit z; int errs;
        ops = '{OP_ART, OP_LOG, OP_CRY, OP_IMM, OP_LD, OP_ST, OP_BEQ, OP_JMP};
        for (int n = 0; n < 150; n++) begin
            instr = {ops[$urandom_range(0, 7)], 14'($urandom)};
            iw = $urandom_range(0, 3); dw = $urandom_range(0, 3); z = 1'($urandom_range(0, 1));
            a = m_pc;
            run_instr(instr, z, iw, dw, a, o);
            model_step(instr, z, iw, dw, e);
            errs = 0;
            total++;
            if (o.timeout || o.lat !== e.lat || o.n_ireq !== e.n_ireq || o.addr_bad) errs++;
            if (o.n_dreq !== e.n_dreq || o.n_dwe !== e.n_dwe || o.n_rfwe !== e.n_rfwe) errs++;
            if (e.n_rfwe == 1 && o.wbsel !== e.wbsel) errs++;
            if (pc !== m_pc || retired !== m_ret || ir !== instr) errs++;
            if (alu_src_imm !== (instr[18:14] == OP_IMM || instr[18:14] == OP_LD || instr[18:14] == OP_ST)) errs++;
            if (errs != 0) begin
                bad++;
                $display("FAIL rand_instr n=%0d ir=%05h lat=%0d/%0d ireq=%0d/%0d dreq=%0d/%0d dwe=%0d/%0d rfwe=%0d/%0d pc=%0h/%0h ret=%0d/%0d (got/want)",
                         n, instr, o.lat, e.lat, o.n_ireq, e.n_ireq, o.n_dreq, e.n_dreq, o.n_dwe, e.n_dwe,
                         o.n_rfwe, e.n_rfwe, pc, m_pc, retired, m_ret);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        int seen;
        bit ok;
        imem_ack = 1'b1; imem_rdata = {OP_ST, 3'd1, 3'd2, 8'h00};
        seen = 0; ok = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            imem_ack = 1'b0; dmem_ack = 1'b0;
            if (dmem_req) seen++;
            if (seen == 2) begin ok = 1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL st_wait_reach dmem_req_cycles=%0d want=2", seen); end
        #2 rst = 1'b1;
        #1;
        total++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || rf_we !== 1'b0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL rst_async_drop dmem_req=%0b dmem_we=%0b rf_we=%0b imem_req=%0b want all 0", dmem_req, dmem_we, rf_we, imem_req);
        end
        @(negedge clk);
        rst = 1'b0; m_pc = '0; m_ret = '0;
        #1;
        total++; if (pc !== '0 || retired !== '0 || imem_addr !== '0 || imem_req !== 1'b1) begin
            bad++; $display("FAIL rst_restart pc=%0h retired=%0d addr=%0h req=%0b want 0 0 0 1", pc, retired, imem_addr, imem_req);
        end
    endtask

    task automatic test_halt();
        obs_t o; exp_t e;
        logic [18:0] instr;
        int strobes;
        instr = {OP_BAD, 14'h1234};
        run_instr(instr, 1'b0, 1, 0, m_pc, o);
        model_step(instr, 1'b0, 1, 0, e);
        total++; if (halted !== 1'b1 || illegal !== 1'b1 || o.lat !== e.lat || retired !== m_ret) begin
            bad++; $display("FAIL illegal_halt halted=%0b illegal=%0b lat=%0d retired=%0d want 1 1 %0d %0d", halted, illegal, o.lat, retired, e.lat, m_ret);
        end
        strobes = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (imem_req || dmem_req || rf_we || !halted) strobes++;
        end
        total++; if (strobes !== 0 || retired !== m_ret) begin
            bad++; $display("FAIL halt_absorbing active_cycles=%0d retired=%0d want 0 %0d", strobes, retired, m_ret);
        end
        do_reset();
        instr = {OP_HLT, 14'h0};
        run_instr(instr, 1'b0, 0, 0, m_pc, o);
        model_step(instr, 1'b0, 0, 0, e);
        total++; if (halted !== 1'b1 || illegal !== 1'b0 || retired !== 16'd0 || o.lat !== 3) begin
            bad++; $display("FAIL hlt_halt halted=%0b illegal=%0b retired=%0d lat=%0d want 1 0 0 3", halted, illegal, retired, o.lat);
        end
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_load_store();
        test_branch();
        test_jmp_wrap();
        test_random();
        test_reset_mid_store();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Multi-cycle instruction sequencer for the 19-bit CPU. It fetches an instruction from instruction memory through a req/ack handshake and latches it. It then walks the datapath through decode, execute, memory and write-back, driving the opcode/funct fields into the ALU control decoder along with the register-file and memory strobes. It sits between the instruction/data memory ports and the register file + ALU datapath, and is the only block that advances the PC.

## Interface
- ADDR_W, 14: PC / memory address width (PC wraps modulo 2^ADDR_W).
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  19  instruction word.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
- dmem_ack  in  1  data access complete this cycle.
- alu_zero  in  1  ALU zero flag (branch compare).
- alu_opcode  out  5  ir[18:14], to ALU control.
- alu_funct  out  5  ir[4:0], to ALU control.
- alu_src_imm  out  1  1 when ALU operand B is the immediate (`IMM, `LD, `ST).
- rf_we  out  1  register-file write strobe.
- wb_sel  out  1  0 = ALU result, 1 = load data.
- ir  out  19  current instruction register.
- pc  out  ADDR_W  program counter (next fetch address).
- halted  out  1  sequencer stopped.
- illegal  out  1  halt cause was an undefined opcode.
- retired  out  16  retired-instruction counter.

## Operation
- Formats: R `[18:14]op [13:11]rd [10:8]rs1 [7:5]rs2 [4:0]funct`; branch `op rs1[13:11] rs2[10:8] off[7:0]`; jump `op target[13:0]`.
- Opcodes are the `parameter.v` macros. ALU class: `ART`, `LOG`, `CRY`, `IMM`. Others: `LD`, `ST`, `BEQ`, `JMP`, `HLT`. Any other value is illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset state FETCH.
- FETCH:
  - imem_req=1 with imem_addr=pc every cycle until imem_ack.
  - On ack: ir<=imem_rdata, pc<=pc+1, go to DECODE.
- DECODE: one cycle, no strobes; alu_src_imm valid from here on.
- EXEC: one cycle, then branch on class:
  - ALU class -> WB.
  - `LD`/`ST` -> MEM.
  - `BEQ`: if alu_zero, pc<=pc+sext(off) (pc already incremented). Then -> FETCH.
  - `JMP`: pc<=target[ADDR_W-1:0]. Then -> FETCH.
  - `HLT` -> HALT.
  - Illegal: illegal<=1, -> HALT.
- MEM: dmem_req=1, dmem_we=(op==`ST`) until dmem_ack.
  - On ack: `LD` -> WB, `ST` -> FETCH.
- WB: rf_we=1 for exactly one cycle; wb_sel=(op==`LD`). Then -> FETCH.
- HALT: absorbing, halted=1, no strobes. Exit only by rst.
- retired increments by 1 on the cycle an instruction completes, wrapping 0xFFFF->0:
  - leaving WB;
  - leaving MEM for `ST`;
  - leaving EXEC for `BEQ`/`JMP`.
  - `HLT` and illegal instructions are not counted.
- alu_opcode/alu_funct are continuous slices of ir.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.

## Timing
- Reset values: pc=0, ir=0, retired=0, illegal=0, halted=0, state FETCH.
- While rst=1, all strobes (imem_req, dmem_req, dmem_we, rf_we) are forced 0.
- All outputs are Moore: functions of registered state/ir only. No combinational path from imem_ack/dmem_ack/alu_zero to any output.
- Zero-wait latency (ack in the first request cycle):
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - `LD`: 5 cycles.
  - `ST`: 4 cycles.
  - `BEQ`/`JMP`: 3 cycles.
- Each wait state adds one cycle; the request stays asserted and the address stays stable.
- Reset mid-transaction: the request drops asynchronously. No write strobe is emitted. The fetch restarts at pc=0 on the first clock after deassertion.
- Branch offset is 8-bit two's complement, added modulo 2^ADDR_W.

## Test plan
- Reset release, imem_ack tied 1, memory word 0 = {`ART`,rd=1,rs1=2,rs2=3,funct=5'd1} -> imem_req cycle 0, alu_opcode=`ART`/alu_funct=1 from cycle 1, rf_we=1 only in cycle 3, pc=1, retired=1.
- `LD` with dmem_ack delayed 3 cycles -> dmem_req high 4 consecutive cycles with dmem_we=0, then rf_we=1 with wb_sel=1; `ST` same delay -> dmem_we=1, rf_we never asserted.
- `BEQ` at pc=5, off=8'hFC: alu_zero=1 -> next imem_addr=2; alu_zero=0 -> next imem_addr=6.
- `JMP` target=14'h3FFF with ADDR_W=14, then an ALU op there -> pc wraps to 0 after that fetch.
- Undefined opcode -> illegal=1, halted=1 after EXEC, imem_req stays 0 for 20 cycles, retired unchanged; `HLT` -> halted=1, illegal=0.
- Assert rst during a MEM wait state of `ST` -> dmem_req falls immediately; after release pc=0, retired=0, first imem_addr=0.
